// File: rtl/pwm_fader_multi.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_fader_multi
//  Description : Multi-channel LED fader. One shared PWM period counter drives
//                CHANNELS comparators; each channel owns a duty/direction pair
//                stepped by a shared fade timer. Modes: static (0/3),
//                synchronous triangle fade (1), staggered fade (2).
//  Ports       : clk          - system clock, rising edge
//                rst_n        - synchronous reset, active low
//                en           - 1 run, 0 freeze state and force outputs low
//                mode         - 0 static, 1 sync fade, 2 staggered, 3 = 0
//                duty_min     - lower fade limit
//                duty_max     - upper fade limit / static duty
//                step         - duty increment per fade step
//                leds         - registered PWM outputs
//                period_start - pulse aligned with the first PWM slot
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_fader_multi #(
    parameter int CLK_FREQ      = 25_000_000,
    parameter int PWM_FREQ      = 1_250,
    parameter int CHANNELS      = 8,
    parameter int DUTY_W        = 16,
    parameter int STEP_CYCLES   = CLK_FREQ / 200,
    parameter int STAGGER_STEPS = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [DUTY_W-1:0]   duty_min,
    input  logic [DUTY_W-1:0]   duty_max,
    input  logic [DUTY_W-1:0]   step,
    output logic [CHANNELS-1:0] leds,
    output logic                period_start
);

    localparam int                  c_PERIOD      = CLK_FREQ / PWM_FREQ;
    localparam logic [DUTY_W-1:0]   c_PERIOD_LAST = DUTY_W'(c_PERIOD - 1);
    localparam int                  c_TMR_W       = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [c_TMR_W-1:0]  c_TMR_LAST    = c_TMR_W'(STEP_CYCLES - 1);
    localparam int                  c_STAG_MAX_I  = (CHANNELS - 1) * STAGGER_STEPS;
    localparam int                  c_STAG_W      = (c_STAG_MAX_I > 0) ? $clog2(c_STAG_MAX_I + 1) : 1;
    localparam logic [c_STAG_W-1:0] c_STAG_MAX    = c_STAG_W'(c_STAG_MAX_I);
    localparam logic [1:0]          c_MODE_SYNC   = 2'd1;
    localparam logic [1:0]          c_MODE_STAG   = 2'd2;

    logic [DUTY_W-1:0]   r_cnt;
    logic [c_TMR_W-1:0]  r_tmr;
    logic [c_STAG_W-1:0] r_stag;
    logic [1:0]          r_mode_prev;

    logic                w_tick;
    logic                w_period_end;
    logic                w_mode_chg;
    logic                w_static;
    logic [CHANNELS-1:0] w_cmp;

    assign w_tick       = en && (r_tmr == c_TMR_LAST);
    assign w_period_end = en && (r_cnt == c_PERIOD_LAST);
    // The previous mode only advances while running, so a mode change made
    // during a freeze is still seen as a change once en returns.
    assign w_mode_chg   = en && (mode != r_mode_prev);
    assign w_static     = (mode != c_MODE_SYNC) && (mode != c_MODE_STAG);

    // Shared period counter, fade step timer and stagger counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_tmr       <= '0;
            r_stag      <= '0;
            // Capture the current mode so leaving reset is not seen as a change
            r_mode_prev <= mode;
        end else if (en) begin
            r_mode_prev <= mode;
            r_cnt       <= w_period_end ? '0 : r_cnt + 1'b1;
            if (w_mode_chg) begin
                r_tmr  <= '0;
                r_stag <= '0;
            end else begin
                r_tmr <= w_tick ? '0 : r_tmr + 1'b1;
                if (w_tick && (mode == c_MODE_STAG) && (r_stag != c_STAG_MAX)) begin
                    r_stag <= r_stag + 1'b1;
                end
            end
        end
    end

    // Output registers, one cycle behind the counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            leds         <= '0;
            period_start <= 1'b0;
        end else begin
            leds         <= en ? w_cmp : '0;
            period_start <= en && (r_cnt == '0);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [DUTY_W-1:0] r_duty;
        logic [DUTY_W-1:0] r_active;
        logic              r_dir_up;
        logic [DUTY_W-1:0] w_fade_duty;
        logic              w_fade_up;
        logic [DUTY_W:0]   w_sum;
        logic [DUTY_W:0]   w_floor;
        logic              w_started;

        if (i == 0) begin : g_first
            assign w_started = 1'b1;
        end else begin : g_rest
            localparam logic [c_STAG_W-1:0] c_START = c_STAG_W'(i * STAGGER_STEPS);
            assign w_started = (mode != c_MODE_STAG) || (r_stag >= c_START);
        end

        assign w_cmp[i] = (r_cnt < r_active);

        // One fade step, evaluated one bit wider so duty+step cannot wrap
        always_comb begin
            w_sum       = {1'b0, r_duty} + {1'b0, step};
            w_floor     = {1'b0, duty_min} + {1'b0, step};
            w_fade_duty = r_duty;
            w_fade_up   = r_dir_up;
            if (duty_min >= duty_max) begin
                w_fade_duty = duty_min;
                w_fade_up   = 1'b1;
            end else if (r_duty > duty_max) begin
                w_fade_duty = duty_max;
            end else if (r_duty < duty_min) begin
                w_fade_duty = duty_min;
            end else if (step == '0) begin
                w_fade_duty = r_duty;
            end else if (r_dir_up) begin
                if (w_sum >= {1'b0, duty_max}) begin
                    w_fade_duty = duty_max;
                    w_fade_up   = 1'b0;
                end else begin
                    w_fade_duty = w_sum[DUTY_W-1:0];
                end
            end else begin
                if ({1'b0, r_duty} <= w_floor) begin
                    w_fade_duty = duty_min;
                    w_fade_up   = 1'b1;
                end else begin
                    w_fade_duty = r_duty - step;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_duty   <= duty_min;
                r_dir_up <= 1'b1;
                r_active <= '0;
            end else if (en) begin
                // Shadow copy only at the period boundary: no mid-period glitches
                if (w_period_end) begin
                    r_active <= r_duty;
                end
                if (w_mode_chg) begin
                    r_duty   <= duty_min;
                    r_dir_up <= 1'b1;
                end else if (w_static) begin
                    r_duty <= duty_max;
                end else if (w_tick) begin
                    if (w_started) begin
                        r_duty   <= w_fade_duty;
                        r_dir_up <= w_fade_up;
                    end else begin
                        r_duty   <= duty_min;
                        r_dir_up <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_fader_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_fader_multi
//  Description : Directed bench for pwm_fader_multi (PERIOD=10, 4 channels,
//                STEP_CYCLES=20, STAGGER_STEPS=2). Each PWM window is measured
//                as a high count per LED and compared to a vector table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_fader_multi;

    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [15:0]   duty_min = '0;
    logic [15:0]   duty_max = '0;
    logic [15:0]   step = '0;
    logic [CH-1:0] leds;
    logic          period_start;

    int n_tests = 0;
    int n_fail  = 0;
    int tab [6];

    typedef struct packed {
        logic [7:0]           win;
        logic [CH-1:0][7:0]   exp;
    } win_vec_t;

    win_vec_t vecs [$];

    always #5 clk = ~clk;

    pwm_fader_multi #(
        .CLK_FREQ      (1000),
        .PWM_FREQ      (100),
        .CHANNELS      (CH),
        .DUTY_W        (16),
        .STEP_CYCLES   (20),
        .STAGGER_STEPS (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .mode         (mode),
        .duty_min     (duty_min),
        .duty_max     (duty_max),
        .step         (step),
        .leds         (leds),
        .period_start (period_start)
    );

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Duty of the 10/4 triangle after n fade steps (0,4,8,10,6,2 repeating)
    function automatic int fd(input int n);
        if (n <= 0) return 0;
        return tab[n % 6];
    endfunction

    function automatic win_vec_t mk(input int w, input int a, input int b, input int c, input int d);
        win_vec_t v;
        v.win    = 8'(w);
        v.exp[0] = 8'(a);
        v.exp[1] = 8'(b);
        v.exp[2] = 8'(c);
        v.exp[3] = 8'(d);
        return v;
    endfunction

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, " reset leds"}, int'(leds), 0);
        check({tag, " reset period_start"}, int'(period_start), 0);
        rst_n = 1'b1;
    endtask

    // Waits for period_start, then counts high samples over 10 cycles
    task automatic measure_window(input string tag, input win_vec_t v);
        int  hi [CH];
        int  ps;
        bit  found;
        found = 1'b0;
        for (int w = 0; w < 30; w++) begin
            @(negedge clk);
            if (period_start) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            check($sformatf("%s win%0d period_start timeout", tag, v.win), 0, 1);
            return;
        end
        ps = 1;
        for (int c = 0; c < CH; c++) hi[c] = int'(leds[c]);
        repeat (9) begin
            @(negedge clk);
            ps += int'(period_start);
            for (int c = 0; c < CH; c++) hi[c] += int'(leds[c]);
        end
        for (int c = 0; c < CH; c++)
            check($sformatf("%s win%0d led%0d high count", tag, v.win, c), hi[c], int'(v.exp[c]));
        check($sformatf("%s win%0d period_start count", tag, v.win), ps, 1);
    endtask

    task automatic run_vecs(input string tag);
        for (int k = 0; k < vecs.size(); k++) measure_window(tag, vecs[k]);
        vecs.delete();
    endtask

    task automatic build_sync(input int first, input int last);
        for (int m = first; m <= last; m++) begin
            int e;
            e = (m == 0) ? 0 : fd((m - 1) / 2);
            vecs.push_back(mk(m, e, e, e, e));
        end
    endtask

    task automatic build_stag(input int first, input int last);
        for (int m = first; m <= last; m++) begin
            int n;
            n = (m == 0) ? -99 : (m - 1) / 2;
            vecs.push_back(mk(m, fd(n), fd(n - 2), fd(n - 4), fd(n - 6)));
        end
    endtask

    initial begin
        int lim [23];
        tab = '{0, 4, 8, 10, 6, 2};

        // Static mode 0, duty_max=3
        en = 1'b1; mode = 2'd0; duty_min = 16'd0; duty_max = 16'd3; step = 16'd1;
        do_reset("s0");
        vecs.push_back(mk(0, 0, 0, 0, 0));
        for (int m = 1; m <= 3; m++) vecs.push_back(mk(m, 3, 3, 3, 3));
        run_vecs("static0");

        // Reserved mode 3 behaves as static
        mode = 2'd3; duty_max = 16'd7;
        do_reset("s3m");
        vecs.push_back(mk(0, 0, 0, 0, 0));
        for (int m = 1; m <= 2; m++) vecs.push_back(mk(m, 7, 7, 7, 7));
        run_vecs("static3");

        // Synchronous fade 0..10 step 4
        mode = 2'd1; duty_min = 16'd0; duty_max = 16'd10; step = 16'd4;
        do_reset("sync");
        build_sync(0, 16);
        run_vecs("sync");

        // Staggered fade, then a one-cycle reset mid-fade
        mode = 2'd2;
        do_reset("stag");
        build_stag(0, 16);
        run_vecs("stag");
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset leds", int'(leds), 0);
        check("midreset period_start", int'(period_start), 0);
        rst_n = 1'b1;
        build_stag(0, 8);
        run_vecs("stag_after_rst");

        // Limit change mid-fade: max 12 -> 5 while falling from 12, then min=max=5
        mode = 2'd1; duty_min = 16'd0; duty_max = 16'd12; step = 16'd4;
        lim = '{0, 0, 0, 4, 4, 8, 8, 10, 10, 8, 8, 5, 5, 1, 1, 0, 0, 4, 4, 5, 5, 5, 5};
        do_reset("lim");
        for (int m = 0; m <= 7; m++) vecs.push_back(mk(m, lim[m], lim[m], lim[m], lim[m]));
        run_vecs("lim12");
        duty_max = 16'd5;
        for (int m = 8; m <= 16; m++) vecs.push_back(mk(m, lim[m], lim[m], lim[m], lim[m]));
        run_vecs("lim5");
        duty_min = 16'd5;
        for (int m = 17; m <= 22; m++) vecs.push_back(mk(m, lim[m], lim[m], lim[m], lim[m]));
        run_vecs("limeq");

        // Freeze for 50 cycles mid-fade
        duty_min = 16'd0; duty_max = 16'd10; step = 16'd4;
        do_reset("frz");
        build_sync(0, 4);
        run_vecs("pre_freeze");
        en = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            check($sformatf("freeze cyc%0d leds", k), int'(leds), 0);
            check($sformatf("freeze cyc%0d period_start", k), int'(period_start), 0);
        end
        en = 1'b1;
        build_sync(5, 12);
        run_vecs("resume");

        // Mode switch 1 -> 2 mid-fade restarts all channels
        mode = 2'd1;
        do_reset("msw");
        build_sync(0, 6);
        run_vecs("msw_sync");
        mode = 2'd2;
        vecs.push_back(mk(7, 10, 10, 10, 10));
        for (int m = 8; m <= 20; m++) begin
            int n;
            n = (m - 8) / 2;
            vecs.push_back(mk(m, fd(n), fd(n - 2), fd(n - 4), fd(n - 6)));
        end
        run_vecs("msw_stag");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
